// File: rtl/packet_framer_if.sv
// Byte-in / word-out stream handshakes
// shared by the packet framer and its environment.
interface packet_framer_if;
  logic [7:0]  in_data;
  logic        in_val;
  logic        in_ready;
  logic [31:0] out_data;
  logic        out_val;
  logic        out_ready;
  logic        out_last;

  modport master (
    input  in_data,
    input  in_val,
    output in_ready,
    output out_data,
    output out_val,
    input  out_ready,
    output out_last
  );

  modport slave (
    output in_data,
    output in_val,
    input  in_ready,
    input  out_data,
    input  out_val,
    output out_ready,
    input  out_last
  );
endinterface

// File: rtl/packet_framer.sv
// Packs a length-framed byte stream into 32-bit words,
// drops packets whose length field is out of range.
module packet_framer #(
  parameter int MAX_LEN = 1500
) (
  input  logic            clk,
  input  logic            reset,
  packet_framer_if.master bus,
  output logic            o_len_err,
  output logic [15:0]     o_pkt_count,
  output logic [7:0]      o_drop_count
);

  typedef enum logic [1:0] {
    ST_LEN,
    ST_FWD,
    ST_DROP
  } state_t;

  localparam logic [15:0] LP_MAX = 16'(MAX_LEN);

  state_t      r_state;
  logic [15:0] r_idx;
  logic [15:0] r_len;
  logic [31:0] r_acc;
  logic        r_acc_full;
  logic        r_acc_last;
  logic [31:0] r_out_data;
  logic        r_out_val;
  logic        r_out_last;
  logic        r_len_err;
  logic [15:0] r_pkt_count;
  logic [7:0]  r_drop_count;

  logic        w_take;
  logic        w_ohs;
  logic        w_out_free;
  logic [1:0]  w_lane;
  logic [15:0] w_len;
  logic        w_len_ok;
  logic        w_end;
  logic        w_done;
  logic        w_drop_evt;
  logic [31:0] w_word;

  assign bus.in_ready = !r_acc_full && !reset;
  assign bus.out_data = r_out_data;
  assign bus.out_val  = r_out_val;
  assign bus.out_last = r_out_last;
  assign o_len_err    = r_len_err;
  assign o_pkt_count  = r_pkt_count;
  assign o_drop_count = r_drop_count;

  assign w_take     = bus.in_val && bus.in_ready;
  assign w_ohs      = r_out_val && bus.out_ready;
  assign w_out_free = !r_out_val || bus.out_ready;
  assign w_lane     = r_idx[1:0];

  // Byte 0 of the length field sits in the top lane.
  assign w_len    = {bus.in_data, r_acc[31:24]};
  assign w_len_ok = (w_len >= 16'd8) &&
                    (w_len <= LP_MAX);
  assign w_end    = (r_idx == r_len - 16'd1);

  assign w_done = w_take &&
                  (r_state == ST_FWD) &&
                  ((w_lane == 2'd3) || w_end);

  assign w_drop_evt = w_take &&
                      (r_state == ST_LEN) &&
                      r_idx[0] &&
                      !w_len_ok;

  always_comb begin
    w_word = (w_lane == 2'd0) ? 32'd0 : r_acc;
    unique case (w_lane)
      2'd0: w_word[31:24] = bus.in_data;
      2'd1: w_word[23:16] = bus.in_data;
      2'd2: w_word[15:8]  = bus.in_data;
      2'd3: w_word[7:0]   = bus.in_data;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_LEN;
      r_idx        <= 16'd0;
      r_len        <= 16'd0;
      r_acc        <= 32'd0;
      r_acc_full   <= 1'b0;
      r_acc_last   <= 1'b0;
      r_out_data   <= 32'd0;
      r_out_val    <= 1'b0;
      r_out_last   <= 1'b0;
      r_len_err    <= 1'b0;
      r_pkt_count  <= 16'd0;
      r_drop_count <= 8'd0;
    end else begin
      r_len_err <= w_drop_evt;

      if (w_ohs && r_out_last)
        r_pkt_count <= r_pkt_count + 16'd1;

      if (w_drop_evt && (r_drop_count != 8'hFF))
        r_drop_count <= r_drop_count + 8'd1;

      // A parked word always goes before a new one.
      if (r_acc_full && w_out_free) begin
        r_out_data <= r_acc;
        r_out_last <= r_acc_last;
        r_out_val  <= 1'b1;
        r_acc_full <= 1'b0;
      end else if (w_done && w_out_free) begin
        r_out_data <= w_word;
        r_out_last <= w_end;
        r_out_val  <= 1'b1;
      end else if (w_ohs) begin
        r_out_val  <= 1'b0;
      end

      if (w_take) begin
        r_acc      <= w_word;
        r_acc_full <= w_done && !w_out_free;
        r_acc_last <= w_end;
        unique case (r_state)
          ST_LEN: begin
            if (!r_idx[0]) begin
              r_idx <= 16'd1;
            end else begin
              r_len <= w_len;
              if (w_len_ok) begin
                r_state <= ST_FWD;
                r_idx   <= 16'd2;
              end else if (w_len <= 16'd2) begin
                r_idx   <= 16'd0;
              end else begin
                r_state <= ST_DROP;
                r_idx   <= 16'd2;
              end
            end
          end
          ST_FWD, ST_DROP: begin
            if (w_end) begin
              r_state <= ST_LEN;
              r_idx   <= 16'd0;
            end else begin
              r_idx   <= r_idx + 16'd1;
            end
          end
          default: begin
            r_state <= ST_LEN;
            r_idx   <= 16'd0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_packet_framer.sv
// Directed bench for packet_framer: vector table plus
// back-to-back, backpressure, reset and saturation cases.
module tb_packet_framer;

  localparam int MAX_LEN = 1500;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        len_err;
  logic [15:0] pkt_count;
  logic [7:0]  drop_count;

  packet_framer_if bus();

  packet_framer #(.MAX_LEN(MAX_LEN)) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .o_len_err    (len_err),
    .o_pkt_count  (pkt_count),
    .o_drop_count (drop_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } wrd_t;

  typedef struct {
    int          mode;
    int          len;
    logic [31:0] seq;
    int          nw;
    logic [31:0] w0;
    logic [31:0] wl;
    bit          drop;
  } vec_t;

  wrd_t rxq[$];
  vec_t vt[11];

  int n_chk = 0;
  int n_pass = 0;
  int rdy_mode = 0;
  int cyc = 0;
  int stall_left = 0;
  bit stall_done = 0;
  bit low_seen = 0;
  int low_at = 0;
  int acc_at_stall = 0;
  int err_cnt = 0;
  int oval_cnt = 0;
  int acc_cnt = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h",
                  nm, act, exp);
  endtask

  // Output side: ready pattern, capture, event counters.
  always @(negedge clk) begin
    #1;
    cyc++;
    case (rdy_mode)
      0: bus.out_ready = 1'b1;
      1: bus.out_ready = 1'b0;
      2: bus.out_ready = (cyc % 4 == 0);
      default: begin
        if (stall_left > 0) begin
          bus.out_ready = 1'b0;
          stall_left--;
        end else begin
          bus.out_ready = 1'b1;
        end
      end
    endcase
    if (len_err) err_cnt++;
    if (bus.out_val) oval_cnt++;
    if (bus.in_val && bus.in_ready) acc_cnt++;
    if (stall_left > 0 && !bus.in_ready && !low_seen) begin
      low_seen = 1;
      low_at = acc_cnt - acc_at_stall;
    end
    if (bus.out_val && bus.out_ready) begin
      rxq.push_back('{bus.out_data, bus.out_last});
      if (rdy_mode == 3 && rxq.size() == 2 && !stall_done) begin
        stall_done = 1;
        stall_left = 20;
        acc_at_stall = acc_cnt;
      end
    end
  end

  function automatic logic [7:0] pkt_byte(input int len,
                                          input logic [31:0] seq,
                                          input int k);
    logic [15:0] l;
    l = 16'(len);
    case (k)
      0: return l[7:0];
      1: return l[15:8];
      2: return 8'h0C;
      3: return 8'h00;
      4: return seq[7:0];
      5: return seq[15:8];
      6: return seq[23:16];
      7: return seq[31:24];
      default: return 8'(k);
    endcase
  endfunction

  function automatic logic [31:0] exp_word(input int len,
                                           input logic [31:0] seq,
                                           input int wi);
    logic [31:0] w;
    w = 32'd0;
    for (int j = 0; j < 4; j++)
      if (wi * 4 + j < len)
        w[31 - 8 * j -: 8] = pkt_byte(len, seq, wi * 4 + j);
    return w;
  endfunction

  task automatic send_byte(input logic [7:0] b);
    int t;
    t = 0;
    bus.in_val  = 1'b1;
    bus.in_data = b;
    while (!bus.in_ready) begin
      @(negedge clk);
      t++;
      if (t > 2000) begin
        n_chk++;
        $display("FAIL in_ready_timeout: got stuck low expected 1");
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $fatal(1, "input stalled");
      end
    end
    @(negedge clk);
    bus.in_val = 1'b0;
  endtask

  task automatic send_pkt(input int len,
                          input logic [31:0] seq,
                          input int nbytes);
    for (int k = 0; k < nbytes; k++)
      send_byte(pkt_byte(len, seq, k));
  endtask

  task automatic wait_rx(input int n);
    int t;
    t = 0;
    while (rxq.size() < n && t < 5000) begin
      @(negedge clk);
      t++;
    end
    repeat (8) @(negedge clk);
  endtask

  task automatic check_stream(input string nm,
                              input int base,
                              input int len,
                              input logic [31:0] seq,
                              input int nw,
                              input logic [31:0] w0,
                              input logic [31:0] wl);
    int bad;
    int lasts;
    if (rxq.size() >= base + nw && nw > 0) begin
      chk({nm, "_w0"}, rxq[base].data, w0);
      chk({nm, "_wlast"}, rxq[base + nw - 1].data, wl);
      bad = 0;
      lasts = 0;
      for (int i = 0; i < nw; i++) begin
        if (rxq[base + i].data !== exp_word(len, seq, i))
          bad++;
        if (rxq[base + i].last) lasts++;
      end
      chk({nm, "_data_errs"}, bad, 0);
      chk({nm, "_last_cnt"}, lasts, 1);
      chk({nm, "_last_pos"}, rxq[base + nw - 1].last, 1);
    end
  endtask

  initial begin
    string nm;
    logic [15:0] pc0;
    logic [7:0]  dc0;
    int e0;
    int v0;
    int nb;
    longint t0;
    int dt;

    vt[0]  = '{0, 20, 32'h1, 5, 32'h14000C00, 32'h10111213, 1'b0};
    vt[1]  = '{0, 5, 32'h1, 0, 32'h0, 32'h0, 1'b1};
    vt[2]  = '{0, 8, 32'h1, 2, 32'h08000C00, 32'h01000000, 1'b0};
    vt[3]  = '{0, 7, 32'h1, 0, 32'h0, 32'h0, 1'b1};
    vt[4]  = '{0, 23, 32'h11223344, 6, 32'h17000C00,
               32'h14151600, 1'b0};
    vt[5]  = '{0, 1536, 32'h1, 0, 32'h0, 32'h0, 1'b1};
    vt[6]  = '{2, 1500, 32'h1, 375, 32'hDC050C00,
               32'hD8D9DADB, 1'b0};
    vt[7]  = '{0, 1501, 32'h1, 0, 32'h0, 32'h0, 1'b1};
    vt[8]  = '{0, 0, 32'h1, 0, 32'h0, 32'h0, 1'b1};
    vt[9]  = '{2, 40, 32'h1, 10, 32'h28000C00,
               32'h24252627, 1'b0};
    vt[10] = '{0, 1, 32'h1, 0, 32'h0, 32'h0, 1'b1};

    bus.in_val  = 1'b0;
    bus.in_data = 8'h00;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_out_val", bus.out_val, 0);
    chk("rst_out_last", bus.out_last, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_len_err", len_err, 0);
    chk("rst_pkt_count", pkt_count, 0);
    chk("rst_drop_count", drop_count, 0);
    chk("rst_in_ready", bus.in_ready, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", bus.in_ready, 1);

    for (int i = 0; i < 11; i++) begin
      rxq.delete();
      pc0 = pkt_count;
      dc0 = drop_count;
      e0 = err_cnt;
      v0 = oval_cnt;
      rdy_mode = vt[i].mode;
      nb = vt[i].drop ? ((vt[i].len < 2) ? 2 : vt[i].len)
                      : vt[i].len;
      nm = $sformatf("v%0d_len%0d", i, vt[i].len);
      t0 = $time;
      send_pkt(vt[i].len, vt[i].seq, nb);
      dt = int'(($time - t0) / 10);
      wait_rx(vt[i].nw);
      chk({nm, "_words"}, rxq.size(), vt[i].nw);
      if (!vt[i].drop)
        check_stream(nm, 0, vt[i].len, vt[i].seq, vt[i].nw,
                     vt[i].w0, vt[i].wl);
      chk({nm, "_pkt_count"}, pkt_count,
          pc0 + (vt[i].drop ? 16'd0 : 16'd1));
      chk({nm, "_drop_count"}, drop_count,
          dc0 + (vt[i].drop ? 8'd1 : 8'd0));
      chk({nm, "_len_err"}, err_cnt - e0, vt[i].drop ? 1 : 0);
      if (vt[i].drop)
        chk({nm, "_no_out_val"}, oval_cnt - v0, 0);
      if (vt[i].mode == 2)
        chk({nm, "_throughput"}, dt <= vt[i].len + 16, 1);
    end

    // Back-to-back 25 then 39: second packet on a fresh word.
    rdy_mode = 0;
    rxq.delete();
    pc0 = pkt_count;
    send_pkt(25, 32'h1, 25);
    send_pkt(39, 32'h1, 39);
    wait_rx(17);
    chk("b2b_words", rxq.size(), 17);
    check_stream("b2b_len25", 0, 25, 32'h1, 7,
                 32'h19000C00, 32'h18000000);
    check_stream("b2b_len39", 7, 39, 32'h1, 10,
                 32'h27000C00, 32'h24252600);
    chk("b2b_pkt_count", pkt_count, pc0 + 16'd2);

    // Short drop immediately followed by a good packet.
    rxq.delete();
    pc0 = pkt_count;
    dc0 = drop_count;
    e0 = err_cnt;
    v0 = oval_cnt;
    send_pkt(5, 32'h1, 5);
    chk("drop5_no_out_val", oval_cnt - v0, 0);
    send_pkt(20, 32'h1, 20);
    wait_rx(5);
    chk("drop5_words", rxq.size(), 5);
    check_stream("drop5_next", 0, 20, 32'h1, 5,
                 32'h14000C00, 32'h10111213);
    chk("drop5_len_err", err_cnt - e0, 1);
    chk("drop5_drop_count", drop_count, dc0 + 8'd1);
    chk("drop5_pkt_count", pkt_count, pc0 + 16'd1);

    // Backpressure: 20 stalled cycles after word 2.
    rxq.delete();
    stall_done = 0;
    low_seen = 0;
    rdy_mode = 3;
    send_pkt(40, 32'h1, 40);
    wait_rx(10);
    chk("bp_words", rxq.size(), 10);
    check_stream("bp", 0, 40, 32'h1, 10,
                 32'h28000C00, 32'h24252627);
    chk("bp_in_ready_fell", low_seen, 1);
    chk("bp_fall_within_8", low_at <= 8, 1);
    rdy_mode = 0;

    // Reset after byte 10 of a 40-byte packet.
    for (int k = 0; k < 11; k++)
      send_byte(pkt_byte(40, 32'h1, k));
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_out_val", bus.out_val, 0);
    chk("mid_rst_out_last", bus.out_last, 0);
    chk("mid_rst_out_data", bus.out_data, 0);
    chk("mid_rst_len_err", len_err, 0);
    chk("mid_rst_pkt_count", pkt_count, 0);
    chk("mid_rst_drop_count", drop_count, 0);
    chk("mid_rst_in_ready", bus.in_ready, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_in_ready_after", bus.in_ready, 1);
    rxq.delete();
    send_pkt(20, 32'h1, 20);
    wait_rx(5);
    chk("mid_rst_words", rxq.size(), 5);
    check_stream("mid_rst_next", 0, 20, 32'h1, 5,
                 32'h14000C00, 32'h10111213);
    chk("mid_rst_next_pkt_count", pkt_count, 1);

    // drop_count saturates at 255.
    for (int i = 0; i < 260; i++)
      send_pkt(0, 32'h1, 2);
    repeat (4) @(negedge clk);
    chk("sat_drop_count", drop_count, 8'd255);
    rxq.delete();
    send_pkt(8, 32'h5, 8);
    wait_rx(2);
    chk("sat_next_words", rxq.size(), 2);
    check_stream("sat_next", 0, 8, 32'h5, 2,
                 32'h08000C00, 32'h05000000);
    chk("sat_pkt_count", pkt_count, 2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
